// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester request/done signals and byte-serial pad signals; master = arbiter side, slave = requesters/pads side
interface mem_bus_arbiter_if;
  logic        r0_rd, r0_wr, r0_done, r1_rd, r1_wr, r1_done;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata, rdata, bus_out, bus_in;
  logic        err, bus_oe, strobe, ack_in;
  logic [1:0]  grant, phase;
  modport master (
    input  r0_rd, r0_wr, r0_addr, r0_wdata, r1_rd, r1_wr, r1_addr, r1_wdata, bus_in, ack_in,
    output r0_done, r1_done, rdata, err, grant, bus_out, bus_oe, strobe, phase
  );
  modport slave (
    output r0_rd, r0_wr, r0_addr, r0_wdata, r1_rd, r1_wr, r1_addr, r1_wdata, bus_in, ack_in,
    input  r0_done, r1_done, rdata, err, grant, bus_out, bus_oe, strobe, phase
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-requester arbiter sequencing ADDR_LO/ADDR_HI/DATA strobe-ack bytes; ports clk, rst, bus (mem_bus_arbiter_if.master)
module mem_bus_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_LOW, ASSERT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [TO_W-1:0] cnt;
  logic [1:0] ph;
  logic [15:0] addr;
  logic [7:0] wdata, rdata_q;
  logic owner, last, wr, done0, done1, err_q;
  logic ack_s, r0_req, r1_req, pick1, take, adv, abort, to;
  assign ack_s = sync[SYNC_STAGES-1];
  assign r0_req = bus.r0_rd | bus.r0_wr;
  assign r1_req = bus.r1_rd | bus.r1_wr;
  assign pick1 = r1_req & (~r0_req | ~last);
  assign to = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
  always_comb begin
    state_n = state;
    take = 1'b0;
    adv = 1'b0;
    abort = 1'b0;
    if (state == IDLE) begin
      take = r0_req | r1_req;
      state_n = take ? WAIT_LOW : IDLE;
    end else if (state == WAIT_LOW) begin
      abort = ack_s & to;
      state_n = !ack_s ? ASSERT : to ? IDLE : WAIT_LOW;
    end else begin
      adv = ack_s;
      abort = !ack_s & to;
      state_n = ack_s ? (ph == 2'd3 ? IDLE : WAIT_LOW) : to ? IDLE : ASSERT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync <= '0;
      cnt <= '0;
      ph <= 2'd0;
      owner <= 1'b0;
      last <= 1'b1;
      wr <= 1'b0;
      addr <= 16'h0;
      wdata <= 8'h0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= 8'h0;
    end else begin
      state <= state_n;
      sync <= {sync[SYNC_STAGES-2:0], bus.ack_in};
      cnt <= (state_n == state && !adv) ? cnt + 1'b1 : '0;
      done0 <= (abort | (adv & (ph == 2'd3))) & ~owner;
      done1 <= (abort | (adv & (ph == 2'd3))) & owner;
      err_q <= abort;
      if (take) begin
        owner <= pick1;
        last <= pick1;
        wr <= pick1 ? bus.r1_wr : bus.r0_wr;
        addr <= pick1 ? bus.r1_addr : bus.r0_addr;
        wdata <= pick1 ? bus.r1_wdata : bus.r0_wdata;
        ph <= 2'd1;
      end
      if (adv) ph <= ph + 2'd1;
      if (adv && ph == 2'd3 && !wr) rdata_q <= bus.bus_in;
    end
  end
  assign bus.strobe = state == ASSERT;
  assign bus.bus_oe = (state != IDLE) & ((ph != 2'd3) | wr);
  assign bus.bus_out = state == IDLE ? 8'h0 : ph == 2'd1 ? addr[7:0] : ph == 2'd2 ? addr[15:8] : wr ? wdata : 8'h0;
  assign bus.grant = state == IDLE ? 2'b00 : {owner, ~owner};
  assign bus.phase = state == IDLE ? 2'd0 : ph;
  assign bus.r0_done = done0;
  assign bus.r1_done = done1;
  assign bus.err = err_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter with a strobe-following responder
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  mem_bus_arbiter_if bif();
  mem_bus_arbiter #(.SYNC_STAGES(2), .TIMEOUT(16), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  logic resp_on = 1'b1;
  logic ack_force = 1'b0;
  logic [7:0] sb_out [64];
  logic [7:0] sb_pre [64];
  logic sb_oe [64];
  logic [1:0] sb_ph [64];
  int nstb = 0;
  logic prev_stb = 1'b0;
  logic [7:0] prev_out = 8'h0;
  always @(negedge clk) begin
    if (bif.strobe === 1'b1 && !prev_stb && nstb < 64) begin
      sb_out[nstb] = bif.bus_out;
      sb_pre[nstb] = prev_out;
      sb_oe[nstb] = bif.bus_oe;
      sb_ph[nstb] = bif.phase;
      nstb++;
    end
    prev_stb = bif.strobe === 1'b1;
    prev_out = bif.bus_out;
  end
  initial begin
    bif.ack_in = 1'b0;
    forever begin
      @(posedge clk);
      #1 bif.ack_in = resp_on ? bif.strobe : ack_force;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic who, input logic wr, input logic [15:0] a, input logic [7:0] d);
    if (who) begin
      bif.r1_rd = !wr; bif.r1_wr = wr; bif.r1_addr = a; bif.r1_wdata = d;
    end else begin
      bif.r0_rd = !wr; bif.r0_wr = wr; bif.r0_addr = a; bif.r0_wdata = d;
    end
  endtask
  task automatic clr_req();
    bif.r0_rd = 1'b0; bif.r0_wr = 1'b0; bif.r1_rd = 1'b0; bif.r1_wr = 1'b0;
  endtask
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 50 && g == 2'b00; i++) begin
      @(negedge clk);
      g = bif.grant;
    end
    chk("grant_seen", g != 2'b00, 1);
  endtask
  task automatic wait_done(output logic [1:0] d, output logic e, output logic [7:0] rd, output int stb_cyc);
    d = 2'b00; e = 1'b0; rd = 8'h0; stb_cyc = 0;
    for (int i = 0; i < 200 && d == 2'b00; i++) begin
      @(negedge clk);
      d = {bif.r1_done, bif.r0_done};
      e = bif.err;
      rd = bif.rdata;
      if (bif.strobe) stb_cyc++;
    end
    chk("done_seen", d != 2'b00, 1);
  endtask
  logic [1:0] g, d;
  logic e;
  logic [7:0] rd;
  int n, b, dn;
  initial begin
    clr_req();
    bif.r0_addr = 16'h0; bif.r1_addr = 16'h0; bif.r0_wdata = 8'h0; bif.r1_wdata = 8'h0;
    bif.bus_in = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bif.strobe, bif.bus_oe, bif.grant, bif.phase, bif.r0_done, bif.r1_done, bif.err}, 0);
    chk("rst_data", {bif.bus_out, bif.rdata}, 0);
    rst = 1'b0;
    // single r0 read
    b = nstb;
    bif.bus_in = 8'hA5;
    set_req(0, 0, 16'h1234, 8'h00);
    wait_grant(g);
    chk("rd_grant", g, 2'b01);
    chk("rd_phase_first", bif.phase, 2'd1);
    clr_req();
    wait_done(d, e, rd, n);
    chk("rd_done", d, 2'b01);
    chk("rd_err", e, 0);
    chk("rd_rdata", rd, 8'hA5);
    chk("rd_grant_at_done", bif.grant, 2'b00);
    chk("rd_nbytes", nstb - b, 3);
    chk("rd_phases", {sb_ph[b], sb_ph[b+1], sb_ph[b+2]}, 6'b01_10_11);
    chk("rd_addr", {sb_out[b], sb_out[b+1]}, 16'h3412);
    chk("rd_oe", {sb_oe[b], sb_oe[b+1], sb_oe[b+2]}, 3'b110);
    chk("rd_stable", {sb_pre[b], sb_pre[b+1]}, 16'h3412);
    @(negedge clk);
    chk("rd_done_1cyc", {bif.r1_done, bif.r0_done}, 0);
    // r1 write
    b = nstb;
    set_req(1, 1, 16'hBEEF, 8'h5A);
    wait_grant(g);
    chk("wr_grant", g, 2'b10);
    clr_req();
    wait_done(d, e, rd, n);
    chk("wr_done", d, 2'b10);
    chk("wr_err", e, 0);
    chk("wr_rdata_held", rd, 8'hA5);
    chk("wr_bytes", {sb_out[b], sb_out[b+1], sb_out[b+2]}, 24'hEFBE5A);
    chk("wr_oe", {sb_oe[b], sb_oe[b+1], sb_oe[b+2]}, 3'b111);
    chk("wr_stable", sb_pre[b+2], 8'h5A);
    // contention, both held for four transfers
    b = nstb;
    bif.bus_in = 8'h77;
    set_req(0, 0, 16'hA011, 8'h00);
    set_req(1, 0, 16'hB022, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, e, rd, n);
      if (k == 3) clr_req();
      chk($sformatf("cont%0d_who", k), d, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_addr", k), {sb_out[b+3*k+1], sb_out[b+3*k]}, (k % 2) ? 16'hB022 : 16'hA011);
    end
    repeat (3) @(negedge clk);
    chk("cont_idle", bif.grant, 2'b00);
    // timeout: responder silent
    resp_on = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    set_req(0, 1, 16'h0077, 8'h99);
    wait_grant(g);
    clr_req();
    wait_done(d, e, rd, n);
    chk("to_done", d, 2'b01);
    chk("to_err", e, 1);
    chk("to_strobe_cycles", n, 16);
    chk("to_rdata_kept", rd, 8'h77);
    chk("to_pads", {bif.strobe, bif.bus_oe}, 0);
    resp_on = 1'b1;
    repeat (4) @(negedge clk);
    bif.bus_in = 8'h3C;
    set_req(0, 0, 16'h0102, 8'h00);
    wait_grant(g);
    clr_req();
    wait_done(d, e, rd, n);
    chk("after_to_done", d, 2'b01);
    chk("after_to_err", e, 0);
    chk("after_to_rdata", rd, 8'h3C);
    // reset during DATA of an r0 write
    set_req(0, 1, 16'h4455, 8'h66);
    wait_grant(g);
    clr_req();
    n = 0;
    for (int i = 0; i < 100 && n == 0; i++) begin
      @(negedge clk);
      if (bif.phase == 2'd3 && bif.strobe) n = 1;
    end
    chk("rst_data_phase_seen", n, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", {bif.strobe, bif.bus_oe, bif.grant, bif.phase, bif.r0_done, bif.r1_done, bif.err}, 0);
    chk("midrst_rdata", bif.rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bif.r0_done || bif.r1_done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    b = nstb;
    bif.bus_in = 8'h5E;
    set_req(0, 0, 16'h0A0B, 8'h00);
    set_req(1, 0, 16'h0C0D, 8'h00);
    wait_grant(g);
    chk("postrst_grant_r0", g, 2'b01);
    clr_req();
    wait_done(d, e, rd, n);
    chk("postrst_done", d, 2'b01);
    chk("postrst_first_phase", sb_ph[b], 2'd1);
    chk("postrst_first_byte", sb_out[b], 8'h0B);
    chk("postrst_rdata", rd, 8'h5E);
    // ack already high when request arrives
    resp_on = 1'b0;
    ack_force = 1'b1;
    repeat (4) @(negedge clk);
    b = nstb;
    bif.bus_in = 8'hC3;
    set_req(1, 0, 16'h9988, 8'h00);
    wait_grant(g);
    chk("ackhi_grant", g, 2'b10);
    clr_req();
    repeat (5) @(negedge clk);
    chk("ackhi_strobe_low", bif.strobe, 0);
    chk("ackhi_bus", {bif.bus_oe, bif.bus_out, bif.phase}, {1'b1, 8'h88, 2'd1});
    chk("ackhi_no_strobe", nstb - b, 0);
    resp_on = 1'b1;
    wait_done(d, e, rd, n);
    chk("ackhi_done", d, 2'b10);
    chk("ackhi_err", e, 0);
    chk("ackhi_rdata", rd, 8'hC3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single byte-serial external memory port (uio pins, ui_in handshake) between two requesters: the CPU core and a debug/DMA loader.
- Grants the port round-robin and sequences each transfer as three handshaken bytes: ADDR_LO, ADDR_HI, DATA.
- Owns the 4-phase strobe/ack protocol, the ack synchroniser and a per-byte timeout, so requesters see a simple request/done interface.

Parameters:
- SYNC_STAGES, 2, flops in the ack_in synchroniser (legal range 2-3).
- TIMEOUT, 255, cycles allowed per handshake wait before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- r0_rd, r0_wr  in  1 each  requester 0 (CPU) read / write request; at most one high.
- r0_addr  in  16  requester 0 address.
- r0_wdata  in  8  requester 0 write data.
- r0_done  out  1  one-cycle completion pulse to requester 0.
- r1_rd, r1_wr, r1_addr, r1_wdata, r1_done  same as r0_*, for requester 1 (debug/DMA).
- rdata  out  8  last read byte; valid when the matching done pulse is high, held until the next read completes.
- err  out  1  high together with a done pulse when that transfer aborted on timeout.
- grant  out  2  one-hot current owner; 00 when idle.
- bus_out  out  8  byte driven to pads.
- bus_oe  out  1  pad output enable.
- bus_in  in  8  pad input byte.
- strobe  out  1  handshake strobe to the external memory.
- ack_in  in  1  asynchronous ack from the external memory.
- phase  out  2  1=ADDR_LO, 2=ADDR_HI, 3=DATA, 0=idle.

Behaviour:
- Reset, applied on a clk edge while rst=1:
  - Outputs go to strobe=0, bus_oe=0, bus_out=0, grant=00, phase=0, r0_done=r1_done=0, err=0, rdata=0.
  - The round-robin pointer resets to requester 0 (favoured first).
  - The synchroniser flops clear.
  - Reset mid-transfer abandons the transfer and issues no done pulse.
- ack_s is ack_in after SYNC_STAGES flops. All protocol decisions use ack_s only.
- Arbiter, IDLE state:
  - Requests are sampled each cycle.
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins; on the first contention after reset, r0 wins.
  - On grant, latch owner, address, wdata and direction into internal registers; go to ADDR_LO on the next cycle.
  - Latched values are used for the rest of the transfer. Requester changes mid-transfer are ignored.
- Byte engine, run for each of ADDR_LO, ADDR_HI, DATA; phase output equals the current byte state:
  - WAIT_LOW sub-state: strobe=0. Wait for ack_s=0.
  - ASSERT sub-state: strobe=1. Wait for ack_s=1.
  - On ack_s=1: strobe drops in the same edge, and the engine advances to the next byte.
- Bus drive per byte:
  - bus_oe=1 with bus_out = addr[7:0] in ADDR_LO, addr[15:8] in ADDR_HI, wdata in DATA for a write.
  - DATA for a read: bus_oe=0, and rdata captures bus_in on the edge where ack_s is seen high.
- Completion:
  - Done pulses the owner's done for exactly one cycle, the cycle after the DATA ack edge.
  - Grant clears the same cycle as done. The arbiter is back in IDLE.
  - A new grant can be issued on the cycle after done, so minimum spacing is one idle cycle.
- Timeout:
  - A counter clears on entry to each wait and increments each waiting cycle.
  - When it reaches TIMEOUT: strobe=0, bus_oe=0, owner done pulses with err=1, rdata is unchanged, return to IDLE.
- Back-to-back: a requester holding its request after done is re-arbitrated normally, so under contention the two requesters alternate.
- Glitch-freedom: bus_out and bus_oe are stable from one cycle before strobe rises until after strobe falls.

Test Plan:
- Single r0 read, addr 0x1234, responder returns 0xA5: phase sequence 1,2,3; bus_out 0x34 then 0x12 with bus_oe=1; DATA byte with bus_oe=0; r0_done one cycle with rdata=0xA5, err=0.
- r1 write, addr 0xBEEF, wdata 0x5A: bus_out 0xEF, 0xBE, 0x5A, with bus_oe=1 throughout; r1_done pulse; r0_done stays 0.
- r0 and r1 requesting in the same cycle, held for 4 transfers: grants alternate r0, r1, r0, r1; each done matches its own address.
- Responder never raises ack, TIMEOUT=16: after 16 waiting cycles in ADDR_LO, strobe=0 and bus_oe=0; r0_done with err=1; next transfer then completes normally.
- rst asserted in the DATA phase of a write: next cycle strobe=0, bus_oe=0, grant=00, no done pulse; a fresh request then begins at ADDR_LO.
- ack_in held high when the request arrives: strobe stays 0 until ack_s goes low; bus_out already shows the low address byte.
